// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register-bank write arbiter.
// Data/byte-enable widths, FSM state type and the byte-merge function.
package reg_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    // Bytes whose enable is low keep the old register contents.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Outputs are meaningful only when req is non-zero.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ byte-enabled writers through a two-state
// round-robin FSM, with a combinational read port.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*ADDR_W-1:0] Addr,
    input  logic [NUM_REQ*DATA_W-1:0] WData,
    input  logic [NUM_REQ*BE_W-1:0]  ByteEn,
    output logic [NUM_REQ-1:0]       Ack,
    output logic                     Err,
    output logic                     Busy,
    input  logic [ADDR_W-1:0]        Rd_Addr,
    output logic [DATA_W-1:0]        Rd_Data
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    lat_idx;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic [BE_W-1:0]     lat_be;
    logic [DATA_W-1:0]   bank [NUM_REGS];

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic                err_nxt;
    logic                busy_nxt;
    logic                start;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];
    logic [BE_W-1:0]     be_arr   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = Addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = WData[i*DATA_W +: DATA_W];
        assign be_arr[i]   = ByteEn[i*BE_W +: BE_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (Req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign start = (state == IDLE) && (|Req);

    always_comb begin
        state_nxt = state;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (|Req) begin
                    state_nxt = WRITE;
                    ack_nxt   = grant;
                    busy_nxt  = 1'b1;
                    err_nxt   = {1'b0, addr_arr[grant_idx]} >= (ADDR_W+1)'(NUM_REGS);
                end
            end
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Ack      <= '0;
            Err      <= 1'b0;
            Busy     <= 1'b0;
            ptr      <= '0;
            lat_idx  <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_be   <= '0;
        end else begin
            state <= state_nxt;
            Ack   <= ack_nxt;
            Err   <= err_nxt;
            Busy  <= busy_nxt;
            if (start) begin
                lat_idx  <= grant_idx;
                lat_addr <= addr_arr[grant_idx];
                lat_data <= data_arr[grant_idx];
                lat_be   <= be_arr[grant_idx];
            end
            if (state == WRITE) begin
                ptr <= (lat_idx == IDX_W'(NUM_REQ-1)) ? '0 : lat_idx + 1'b1;
            end
        end
    end

    // Out-of-range latched addresses match no register, so the bank is untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                bank[r] <= '0;
            end
        end else if (state == WRITE) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (lat_addr == ADDR_W'(r)) begin
                    bank[r] <= be_merge(bank[r], lat_data, lat_be);
                end
            end
        end
    end

    always_comb begin
        Rd_Data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (Rd_Addr == ADDR_W'(r)) begin
                Rd_Data = bank[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed steps plus randomized
// traffic checked against a behavioural round-robin/bank model.
module tb_reg_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NREGS = 12;
    localparam int AW    = 4;

    logic              Clk;
    logic              Reset;
    logic [NREQ-1:0]   Req;
    logic [NREQ*AW-1:0] Addr;
    logic [NREQ*32-1:0] WData;
    logic [NREQ*4-1:0] ByteEn;
    logic [NREQ-1:0]   Ack;
    logic              Err;
    logic              Busy;
    logic [AW-1:0]     Rd_Addr;
    logic [31:0]       Rd_Data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mbank [16];
    int          mptr;

    reg_bank_arbiter #(
        .NUM_REQ  (NREQ),
        .NUM_REGS (NREGS),
        .ADDR_W   (AW)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .Addr    (Addr),
        .WData   (WData),
        .ByteEn  (ByteEn),
        .Ack     (Ack),
        .Err     (Err),
        .Busy    (Busy),
        .Rd_Addr (Rd_Addr),
        .Rd_Data (Rd_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference rule: first requesting index found scanning upward from ptr, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        return (int'(a) < NREGS) ? mbank[a] : 32'h0;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        Addr[i*AW +: AW]  = a;
        WData[i*32 +: 32] = d;
        ByteEn[i*4 +: 4]  = be;
        Req[i]            = 1'b1;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            Rd_Addr = AW'(a);
            #1;
            chk($sformatf("%s rd[%0d]", tag, a), Rd_Data, model_rd(AW'(a)));
        end
    endtask

    task automatic wait_ack(output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        while (idx < 0 && cyc < 12) begin
            @(posedge Clk);
            #1;
            cyc++;
            for (int i = 0; i < NREQ; i++) if (Ack[i] && idx < 0) idx = i;
        end
        if (idx < 0) begin
            tests++;
            fails++;
            $error("FAIL ack_timeout: observed no Ack within %0d cycles, required one", cyc);
        end
    endtask

    // Waits for the next grant and checks the whole two-cycle transaction.
    task automatic serve(input int exp_idx, input int exp_cyc, input string tag);
        int idx, cyc;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
        wait_ack(idx, cyc);
        if (idx < 0) return;
        a  = Addr[exp_idx*AW +: AW];
        d  = WData[exp_idx*32 +: 32];
        be = ByteEn[exp_idx*4 +: 4];
        chk({tag, " grant"}, 32'(Ack), 32'(1) << exp_idx);
        if (exp_cyc > 0) chk({tag, " latency"}, cyc, exp_cyc);
        chk({tag, " busy"}, 32'(Busy), 32'(1));
        chk({tag, " err"}, 32'(Err), (int'(a) >= NREGS) ? 32'(1) : 32'(0));
        Rd_Addr = a;
        #1;
        chk({tag, " rd_old"}, Rd_Data, model_rd(a));
        Req[idx] = 1'b0;
        if (int'(a) < NREGS) mbank[a] = merge(mbank[a], d, be);
        mptr = (exp_idx + 1) % NREQ;
        @(posedge Clk);
        #1;
        chk({tag, " ack_clr"}, 32'(Ack), 32'(0));
        chk({tag, " busy_clr"}, 32'(Busy), 32'(0));
        chk({tag, " err_clr"}, 32'(Err), 32'(0));
        chk({tag, " rd_new"}, Rd_Data, model_rd(a));
    endtask

    initial begin
        Reset   = 1'b1;
        Req     = '0;
        Addr    = '0;
        WData   = '0;
        ByteEn  = '0;
        Rd_Addr = '0;
        mptr    = 0;
        for (int r = 0; r < 16; r++) mbank[r] = 32'h0;

        repeat (3) @(posedge Clk);
        #1;
        chk("reset ack", 32'(Ack), 32'(0));
        chk("reset err", 32'(Err), 32'(0));
        chk("reset busy", 32'(Busy), 32'(0));
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("idle ack", 32'(Ack), 32'(0));
        sweep("reset");

        // single full-word write
        set_req(0, 4'd3, 32'hDEADBEEF, 4'hF);
        serve(0, 1, "single");
        Rd_Addr = 4'd3;
        #1;
        chk("single value", Rd_Data, 32'hDEADBEEF);

        // partial byte write
        set_req(1, 4'd5, 32'h11223344, 4'hF);
        serve(1, 1, "preload");
        set_req(2, 4'd5, 32'hAABBCCDD, 4'b0101);
        serve(2, 1, "partial");
        Rd_Addr = 4'd5;
        #1;
        chk("partial value", Rd_Data, 32'h11BB33DD);

        // bring the pointer back to 0, then full contention
        set_req(3, 4'd0, $urandom, 4'hF);
        serve(3, 1, "wrap");
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(8 + i), $urandom, 4'hF);
        for (int i = 0; i < NREQ; i++) serve(i, 1, $sformatf("contend%0d", i));
        set_req(0, 4'd1, $urandom, 4'hF);
        set_req(3, 4'd2, $urandom, 4'hF);
        serve(0, 1, "req1001 first");
        serve(3, 1, "req1001 second");

        // out-of-range address: Ack and Err pulse, bank untouched
        set_req(1, 4'd13, 32'hCAFEF00D, 4'hF);
        serve(1, 1, "oor");
        sweep("oor");

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!Req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            end
            if (Req == '0) set_req(int'($urandom_range(0, NREQ-1)), AW'($urandom_range(0, 15)),
                                   $urandom, 4'($urandom_range(0, 15)));
            serve(pick(Req, mptr), 1, $sformatf("rnd%0d", n));
        end
        while (Req != '0) serve(pick(Req, mptr), 1, "drain");
        sweep("random");

        // reset in the middle of a write aborts it
        set_req(2, 4'd7, 32'h5A5A5A5A, 4'hF);
        @(posedge Clk);
        #1;
        chk("abort busy", 32'(Busy), 32'(1));
        Reset = 1'b1;
        Req   = '0;
        #1;
        chk("abort ack", 32'(Ack), 32'(0));
        chk("abort busy_clr", 32'(Busy), 32'(0));
        for (int r = 0; r < 16; r++) mbank[r] = 32'h0;
        mptr = 0;
        Rd_Addr = 4'd7;
        #1;
        chk("abort target", Rd_Data, 32'h0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("abort no ack", 32'(Ack), 32'(0));
        sweep("abort");
        set_req(0, 4'd4, $urandom, 4'hF);
        set_req(1, 4'd6, $urandom, 4'hF);
        serve(0, 1, "post-reset first");
        serve(1, 1, "post-reset second");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
